// File: rtl/arya_mem_loader.sv
// arya_mem_loader: streams an image into arya's memory, optionally reads it back, and gates core_en on matching checksums.
// Define ARYA_LOADER_VERIFY_EN to build the readback phase; without it LOAD goes straight to DONE.
module arya_mem_loader #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATAPATH_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [MEM_ADDR_WIDTH:0]   word_count,
    input  logic [DATAPATH_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
    output logic [DATAPATH_WIDTH-1:0] mem_wdata_out,
    output logic                      setup_mem,
    output logic                      verify_mem,
    input  logic [DATAPATH_WIDTH-1:0] mem_rdata_in,
    output logic                      core_en,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [DATAPATH_WIDTH-1:0] checksum
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = DATAPATH_WIDTH;
`ifdef ARYA_LOADER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, LOAD, VFY_RD, VFY_DRAIN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
    state_t state, state_nxt;
    logic [AW-1:0] base, ptr;
    logic [AW:0] cnt, rem;
    logic [DW-1:0] ld_sum;
    logic start_ok, accept, last, issue, match;
    assign start_ok = start && (state == IDLE || state == DONE);
    assign accept = state == LOAD && in_valid;
    assign last = rem == (AW+1)'(1);
`ifdef ARYA_LOADER_VERIFY_EN
    logic [DW-1:0] vf_sum;
    logic rd_pend;
    assign issue = state == VFY_RD;
    // Readback data arrives one cycle after its address, so fold on the delayed issue flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            vf_sum <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= issue;
            if (start_ok) vf_sum <= '0;
            else if (rd_pend) vf_sum <= {vf_sum[DW-2:0], vf_sum[DW-1]} ^ mem_rdata_in;
        end
    end
    assign match = vf_sum == ld_sum;
    assign verify_mem = state == VFY_RD || state == VFY_DRAIN;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata_in;
    assign issue = 1'b0;
    assign match = 1'b1;
    assign verify_mem = 1'b0;
`endif
    // The last accepted word rewinds ptr/rem so the readback pass reuses them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            base <= '0;
            cnt <= '0;
            ptr <= '0;
            rem <= '0;
            ld_sum <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                base <= base_addr;
                cnt <= word_count;
                ptr <= base_addr;
                rem <= word_count;
                ld_sum <= '0;
            end else if (accept) begin
                ld_sum <= {ld_sum[DW-2:0], ld_sum[DW-1]} ^ in_data;
                ptr <= last ? base : ptr + 1'b1;
                rem <= last ? cnt : rem - 1'b1;
            end else if (issue) begin
                ptr <= ptr + 1'b1;
                rem <= rem - 1'b1;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        if (start_ok) state_nxt = word_count == '0 ? DONE : LOAD;
`ifdef ARYA_LOADER_VERIFY_EN
        else if (accept && last) state_nxt = VFY_RD;
        else if (issue && last) state_nxt = VFY_DRAIN;
        else if (state == VFY_DRAIN) state_nxt = DONE;
`else
        else if (accept && last) state_nxt = DONE;
`endif
    end
    assign in_ready = state == LOAD;
    assign setup_mem = accept;
    assign mem_addr_out = (accept || issue) ? ptr : '0;
    assign mem_wdata_out = accept ? in_data : '0;
    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;
    assign pass = done && match;
    assign core_en = pass;
    assign checksum = ld_sum;
endmodule
